branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side counterpart of the branch comparator. It predicts taken/not-taken and the target
//  for each fetch PC from a direct-mapped table (valid, tag, target, 2-bit saturating counter).
//  It trains on the resolved outcome (comparator res) and raises a registered mispredict/redirect.
//  Sits between the fetch PC mux and the execute-stage branch unit.
// PARAMETERS
//  XLEN     32   address/data width
//  ENTRIES  64   table entries; power of 2, >=2; IDX_W=log2(ENTRIES), TAG_W=XLEN-2-IDX_W
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst_n           in   1     asynchronous active-low reset
//  flush           in   1     sync: clear all valid bits (counters/targets kept)
//  lk_pc           in   XLEN  fetch PC to look up (word aligned)
//  lk_taken        out  1     predicted taken (combinational)
//  lk_target       out  XLEN  predicted target; equals lk_pc+4 when lk_taken=0
//  upd_en          in   1     resolved conditional branch this cycle
//  upd_pc          in   XLEN  PC of the resolved branch
//  upd_taken       in   1     actual outcome (comparator res)
//  upd_target      in   XLEN  actual taken target
//  upd_pred_taken  in   1     prediction that was used for this branch
//  upd_pred_target in   XLEN  predicted target that was used
//  mispredict      out  1     1-cycle pulse, registered
//  redirect_pc     out  XLEN  correct next PC, valid while mispredict=1
// BEHAVIOUR
//  - Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
//  - Lookup: hit = valid[idx] & tag match. lk_taken = hit & ctr[1]. lk_target = lk_taken ? target : lk_pc+4 (mod 2^XLEN).
//  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; saturates at 00/11.
//  - Update (edge after upd_en=1):
//      hit: ctr +1 if upd_taken, -1 otherwise; target<=upd_target if upd_taken.
//      miss & upd_taken: allocate (evict) with valid=1, tag, target=upd_target, ctr=10.
//      miss & !upd_taken: no table change.
//  - Mispredict: mis = upd_en & ((upd_taken!=upd_pred_taken) | (upd_taken & upd_pred_target!=upd_target)).
//    Next edge: mispredict<=mis; redirect_pc<= upd_taken ? upd_target : upd_pc+4. Latency 1 cycle.
//    If mis=0 the next edge gives mispredict=0; redirect_pc holds its last value.
//  - Same-cycle lookup and update to the same index: lookup returns pre-update contents (write-after-read).
//  - flush & upd_en in the same cycle: flush wins for valid bits; a miss-allocate is discarded.
//    The hit-path counter update still applies, and mispredict is still generated.
//  - Reset (async, any time incl. mid-update): all valid=0, ctr=01, targets=0, mispredict=0, redirect_pc=0.
//    Outputs are immediately lk_taken=0 and lk_target=lk_pc+4.
//  - No backpressure; at most one update per cycle; upd_en=0 -> table unchanged.
// STRUCTURE
//  - Shared package: counter encoding constants (CTR_SNT..CTR_ST), PC_STEP=4, and the index/tag width helper function.
//  - Sub-module sat_counter2 (2-bit saturating inc/dec, combinational next-state).
//    Instantiate it once on the update path.
//  - Tables are flop arrays (valid needs async reset + flush); target/tag may be plain regs without reset.
// TESTING
//  1. Reset, lk_pc=0x100 -> lk_taken=0, lk_target=0x104, mispredict=0.
//  2. Update pc=0x100, taken=1, target=0x200, pred_taken=0:
//     next cycle mispredict=1, redirect_pc=0x200; lookup 0x100 -> taken, 0x200.
//  3. Three more taken updates at 0x100 (ctr saturates at 11), then two not-taken:
//     ctr=01, lookup 0x100 -> not taken; the second NT with pred_taken=1 -> redirect_pc=0x104.
//  4. Aliasing (ENTRIES=64): taken update 0x100 then 0x200 (same idx, different tag) -> 0x100 misses; 0x200 hits.
//  5. Same-cycle lookup+update at 0x300 (first taken) -> lookup that cycle NT; next cycle taken.
//     Also flush+update in one cycle -> entry not valid afterwards.
//  6. Assert rst_n low mid-stream after pending mis -> mispredict drops immediately, all lookups NT.
//  7. Correct prediction (pred_taken=1, pred_target=upd_target) -> no mispredict pulse.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor slice.
//  - 2-bit saturating counter encoding (strong/weak not-taken/taken)
//  - sequential PC step
//  - index/tag width helpers derived from XLEN and the table size
package branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken (reset value)
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken (fresh allocation)
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  localparam int PC_STEP = 4;

  // Index bits select a table entry above the two word-alignment bits.
  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  // Tag covers every PC bit above the index.
  function automatic int tag_width(input int xlen, input int entries);
    return xlen - 2 - $clog2(entries);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, next-state only (no storage).
// Ports:
//   ctr_i  current counter value
//   inc_i  1 = count up (taken), 0 = count down (not taken)
//   ctr_o  next counter value, saturating at CTR_SNT / CTR_ST
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves ctr_o
    // unassigned; otherwise a latch is inferred.
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor (valid, tag, target, 2-bit counter per entry).
// Predicts direction/target for the fetch PC, trains on resolved branches and
// raises a registered mispredict pulse with the corrected next PC.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      clear all valid bits (counters/targets kept)
//   lk_pc                      fetch PC to look up
//   lk_taken, lk_target        combinational prediction (target = pc+4 if NT)
//   upd_en, upd_pc             a conditional branch resolved this cycle
//   upd_taken, upd_target      actual outcome and taken target
//   upd_pred_taken/_target     prediction that fetch actually used
//   mispredict, redirect_pc    registered 1-cycle pulse and correct next PC
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int IDX_W = idx_width(ENTRIES);
  localparam int TAG_W = tag_width(XLEN, ENTRIES);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic            mispredict_q;
  logic [XLEN-1:0] redirect_q;

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx    = lk_pc[IDX_W+1:2];
  assign lk_tag    = lk_pc[XLEN-1:IDX_W+2];
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  // Reads see the table before this cycle's update lands, so a same-index
  // lookup and update naturally return the pre-update contents.
  assign lk_taken  = lk_hit & ctr_q[lk_idx][1];
  assign lk_target = lk_taken ? target_q[lk_idx] : lk_pc + STEP;

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       ctr_d;
  logic             do_train;
  logic             do_alloc;

  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[XLEN-1:IDX_W+2];
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign do_train = upd_en & upd_hit;
  // A flush in the same cycle discards a miss allocation entirely.
  assign do_alloc = upd_en & ~upd_hit & upd_taken & ~flush;

  sat_counter2 u_ctr (
    .ctr_i (ctr_q[upd_idx]),
    .inc_i (upd_taken),
    .ctr_o (ctr_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n)        valid_q <= '0;
    else if (flush)    valid_q <= '0;
    else if (do_alloc) valid_q[upd_idx] <= 1'b1;
  end

  // Counters and targets have defined reset contents; the hit-path training
  // still applies when a flush coincides with the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]    <= CTR_WNT;
        target_q[i] <= '0;
      end
    end else if (do_train) begin
      ctr_q[upd_idx] <= ctr_d;
      if (upd_taken) target_q[upd_idx] <= upd_target;
    end else if (do_alloc) begin
      ctr_q[upd_idx]    <= CTR_WT;
      target_q[upd_idx] <= upd_target;
    end
  end

  // NOTE: tags are only meaningful behind a set valid bit, so this array is
  // left without reset; resetting it would add a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (do_alloc) tag_q[upd_idx] <= upd_tag;
  end

  // ------------------------------------------------------------ mispredict
  logic mis;

  assign mis = upd_en & ((upd_taken != upd_pred_taken) |
                         (upd_taken & (upd_pred_target != upd_target)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= mis;
      if (mis) redirect_q <= upd_taken ? upd_target : upd_pc + STEP;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;

  // Word-alignment bits never take part in indexing or tagging.
  logic unused_lsbs;
  assign unused_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized updates/lookups compared against a table model kept here.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] lk_pc;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  branch_predictor #(.XLEN(32), .ENTRIES(ENTRIES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .lk_pc           (lk_pc),
    .lk_taken        (lk_taken),
    .lk_target       (lk_target),
    .upd_en          (upd_en),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  bit          m_mis;
  logic [31:0] m_redir;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_ctr[i]    = 1;
      m_target[i] = 32'h0;
      m_tag[i]    = 32'h0;
    end
    m_mis   = 1'b0;
    m_redir = 32'h0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    tk = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    tg = tk ? m_target[i] : pc + 32'd4;
  endtask

  // Applies the effect of the current update/flush inputs at a clock edge.
  task automatic m_update();
    int i;
    bit hit;
    i   = idx_of(upd_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
    if (upd_en) begin
      if (hit) begin
        if (upd_taken) begin
          m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken && !flush) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upd_pc);
        m_target[i] = upd_target;
        m_ctr[i]    = 2;
      end
    end
    if (flush) for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
  endtask

  // One clock: check lookup before the edge, then the registered outputs.
  task automatic cycle();
    logic        tk;
    logic [31:0] tg;
    bit          mis;
    logic [31:0] rd;
    #1;
    m_lookup(lk_pc, tk, tg);
    check("lk_taken", {31'b0, lk_taken}, {31'b0, tk});
    check("lk_target", lk_target, tg);
    mis = upd_en && ((upd_taken != upd_pred_taken) ||
                     (upd_taken && (upd_pred_target != upd_target)));
    rd  = upd_taken ? upd_target : upd_pc + 32'd4;
    @(posedge clk);
    m_update();
    m_mis = mis;
    if (mis) m_redir = rd;
    #1;
    check("mispredict", {31'b0, mispredict}, {31'b0, m_mis});
    check("redirect_pc", redirect_pc, m_redir);
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                       input logic [31:0] lk, input logic fl);
    upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt; lk_pc = lk; flush = fl;
    cycle();
    upd_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tg);
    lk_pc = pc;
    #1;
    check({tag, "_taken"}, {31'b0, lk_taken}, {31'b0, tk});
    check({tag, "_target"}, lk_target, tg);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] his [4] = '{32'h0, 32'h100, 32'h200, 32'hFFFF_FF00};
    int idx;
    idx = $urandom_range(0, 7);
    if ($urandom_range(0, 7) == 0) idx = ENTRIES - 1;
    return his[$urandom_range(0, 3)] + 32'(idx * 4);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; lk_pc = 32'h100; upd_en = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    m_reset();
    #12;
    check("rst_taken", {31'b0, lk_taken}, 32'h0);
    check("rst_target", lk_target, 32'h104);
    check("rst_mispredict", {31'b0, mispredict}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // First taken resolve allocates and mispredicts.
    drive(1, 32'h100, 1, 32'h200, 0, 32'h0, 32'h100, 0);
    check("t2_mispredict", {31'b0, mispredict}, 32'h1);
    check("t2_redirect", redirect_pc, 32'h200);
    probe("t2_lk", 32'h100, 1, 32'h200);

    // Saturate at strong-taken, then walk back to weak-not-taken.
    repeat (3) drive(1, 32'h100, 1, 32'h200, 1, 32'h200, 32'h100, 0);
    drive(1, 32'h100, 0, 32'h200, 1, 32'h200, 32'h100, 0);
    drive(1, 32'h100, 0, 32'h200, 1, 32'h200, 32'h100, 0);
    check("t3_redirect", redirect_pc, 32'h104);
    probe("t3_lk", 32'h100, 0, 32'h104);

    // Aliasing: 0x200 evicts 0x100 from the shared entry.
    drive(1, 32'h200, 1, 32'h300, 0, 32'h0, 32'h200, 0);
    probe("t4_old", 32'h100, 0, 32'h104);
    probe("t4_new", 32'h200, 1, 32'h300);

    // Same-cycle lookup+update sees pre-update state; then flush+update.
    drive(1, 32'h300, 1, 32'h500, 0, 32'h0, 32'h300, 0);
    probe("t5_after", 32'h300, 1, 32'h500);
    drive(1, 32'h400, 1, 32'h600, 0, 32'h0, 32'h400, 1);
    check("t5_flush_mis", {31'b0, mispredict}, 32'h1);
    probe("t5_flushed", 32'h400, 0, 32'h404);
    probe("t5_flushed_old", 32'h300, 0, 32'h304);

    // Correct prediction gives no pulse and redirect holds.
    drive(1, 32'h500, 1, 32'h700, 0, 32'h0, 32'h500, 0);
    drive(1, 32'h500, 1, 32'h700, 1, 32'h700, 32'h500, 0);
    check("t7_no_mis", {31'b0, mispredict}, 32'h0);
    check("t7_hold", redirect_pc, 32'h700);

    // Asynchronous reset with a pending pulse and an update in flight.
    drive(1, 32'h500, 0, 32'h0, 1, 32'h700, 32'h500, 0);
    check("t6_pending", {31'b0, mispredict}, 32'h1);
    upd_en = 1'b1; upd_taken = 1'b1; upd_pc = 32'h800; upd_target = 32'h900;
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    check("t6_mis_drop", {31'b0, mispredict}, 32'h0);
    check("t6_redir_clr", redirect_pc, 32'h0);
    probe("t6_lk_a", 32'h500, 0, 32'h504);
    probe("t6_lk_b", 32'h100, 0, 32'h104);
    @(negedge clk);
    rst_n = 1'b1; upd_en = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic over a small set of aliasing PCs.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, tgt, ptgt;
      logic        tk, ptk;
      pc  = rand_pc();
      tgt = rand_pc();
      tk  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) m_lookup(pc, ptk, ptgt);
      else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = ($urandom_range(0, 1) == 0) ? tgt : rand_pc();
      end
      drive(1'($urandom_range(0, 3) != 0), pc, tk, tgt, ptk, ptgt, rand_pc(),
            1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
